// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M divide/remainder sequencer: operand
// width, funct3 codes, FSM state encoding, special-case constants and
// small arithmetic helpers.
package rv32m_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    // funct3 codes of the divide group
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

    // Special-case operand/result values
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] XLEN_ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] XLEN_ONE  = {{(XLEN-1){1'b0}}, 1'b1};

    // Iteration counter constants: XLEN iterations run from XLEN-1 down to 0
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Two's-complement negation, wrapping modulo 2^XLEN
    function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] v);
        return (~v) + XLEN_ONE;
    endfunction

    // DIV and REM interpret operands as signed; everything else is unsigned
    function automatic logic is_signed_op(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // REM and REMU return the remainder; all other codes return the quotient
    function automatic logic is_rem_op(input logic [2:0] f3);
        return (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring-division iteration: shift {rem, quo} left by one,
// try subtracting the divisor, keep the difference when it is non-negative
// and shift the resulting quotient bit into quo[0].
module div_restore_step
    import rv32m_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    // The shifted partial remainder needs XLEN+1 bits; the stored remainder
    // is always below the divisor, so it fits back into XLEN bits.
    logic [XLEN:0] rem_sh_s;
    logic [XLEN:0] trial_s;

    // Trial subtraction; its MSB is the sign that decides restore vs keep
    always_comb begin
        rem_sh_s = {rem, quo[XLEN-1]};
        trial_s  = rem_sh_s - {1'b0, divisor};
        if (trial_s[XLEN] == 1'b0) begin
            rem_next = trial_s[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = rem_sh_s[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU controller for the EX stage. Runs XLEN
// restoring-division iterations, short-circuits divide-by-zero and signed
// overflow, holds stall while busy and returns the result with its rd tag.
module div_sequencer
    import rv32m_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    div_state_e       state_r;
    div_state_e       state_nxt_s;

    logic [2:0]       funct3_r;
    logic [XLEN-1:0]  a_r;
    logic [XLEN-1:0]  b_r;
    logic [4:0]       rd_r;
    logic [XLEN-1:0]  rem_r;
    logic [XLEN-1:0]  quo_r;
    logic [XLEN-1:0]  dvs_r;
    logic [CNT_W-1:0] cnt_r;
    logic             qneg_r;
    logic             rneg_r;
    logic [XLEN-1:0]  result_r;

    logic             signed_s;
    logic             rem_op_s;
    logic             div_zero_s;
    logic             ovf_s;
    logic             fast_s;
    logic [XLEN-1:0]  abs_a_s;
    logic [XLEN-1:0]  abs_b_s;
    logic [XLEN-1:0]  fix_q_s;
    logic [XLEN-1:0]  fix_r_s;
    logic [XLEN-1:0]  rem_step_s;
    logic [XLEN-1:0]  quo_step_s;

    div_restore_step u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvs_r),
        .rem_next (rem_step_s),
        .quo_next (quo_step_s)
    );

    // Operand decode, magnitudes, special cases and final sign correction
    always_comb begin
        signed_s   = is_signed_op(funct3_r);
        rem_op_s   = is_rem_op(funct3_r);
        abs_a_s    = (signed_s && a_r[XLEN-1]) ? neg2c(a_r) : a_r;
        abs_b_s    = (signed_s && b_r[XLEN-1]) ? neg2c(b_r) : b_r;
        div_zero_s = (b_r == XLEN_ZERO);
        ovf_s      = signed_s && (a_r == INT_MIN) && (b_r == ALL_ONES);
        fast_s     = div_zero_s || ovf_s;
        fix_q_s    = qneg_r ? neg2c(quo_r) : quo_r;
        fix_r_s    = rneg_r ? neg2c(rem_r) : rem_r;
    end

    // State register; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush abandons any operation still being computed
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !flush) state_nxt_s = ST_PREP;
                else                 state_nxt_s = ST_IDLE;
            end
            ST_PREP: begin
                if (flush)       state_nxt_s = ST_IDLE;
                else if (fast_s) state_nxt_s = ST_DONE;
                else             state_nxt_s = ST_CALC;
            end
            ST_CALC: begin
                if (flush)                  state_nxt_s = ST_IDLE;
                else if (cnt_r == CNT_ZERO) state_nxt_s = ST_FIX;
                else                        state_nxt_s = ST_CALC;
            end
            ST_FIX: begin
                if (flush) state_nxt_s = ST_IDLE;
                else       state_nxt_s = ST_DONE;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        stall = 1'b0;
        done  = 1'b0;
        case (state_r)
            ST_PREP, ST_CALC, ST_FIX: stall = 1'b1;
            ST_DONE:                  done  = 1'b1;
            default: begin
                stall = 1'b0;
                done  = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, setup, iteration and result selection
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_r <= 3'd0;
            a_r      <= XLEN_ZERO;
            b_r      <= XLEN_ZERO;
            rd_r     <= 5'd0;
            rem_r    <= XLEN_ZERO;
            quo_r    <= XLEN_ZERO;
            dvs_r    <= XLEN_ZERO;
            cnt_r    <= CNT_ZERO;
            qneg_r   <= 1'b0;
            rneg_r   <= 1'b0;
            result_r <= XLEN_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !flush) begin
                        funct3_r <= funct3;
                        a_r      <= rs1_val;
                        b_r      <= rs2_val;
                        rd_r     <= rd_in;
                    end
                end
                ST_PREP: begin
                    rem_r  <= XLEN_ZERO;
                    quo_r  <= abs_a_s;
                    dvs_r  <= abs_b_s;
                    cnt_r  <= CNT_LAST;
                    qneg_r <= signed_s && (a_r[XLEN-1] ^ b_r[XLEN-1]);
                    rneg_r <= signed_s && a_r[XLEN-1];
                    if (div_zero_s) begin
                        result_r <= rem_op_s ? a_r : ALL_ONES;
                    end else if (ovf_s) begin
                        result_r <= rem_op_s ? XLEN_ZERO : INT_MIN;
                    end
                end
                ST_CALC: begin
                    rem_r <= rem_step_s;
                    quo_r <= quo_step_s;
                    cnt_r <= cnt_r - CNT_ONE;
                end
                ST_FIX: begin
                    result_r <= rem_op_s ? fix_r_s : fix_q_s;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign result = result_r;
    assign rd_out = rd_r;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus random
// operations compared against a plain-arithmetic RV32M reference model.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    div_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .flush   (flush),
        .stall   (stall),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // RISC-V M-extension divide semantics, straight from the ISA rules
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        logic want_rem;
        int   sa;
        int   sb;
        sgn      = (f3 == 3'b100) || (f3 == 3'b110);
        want_rem = (f3 == 3'b110) || (f3 == 3'b111);
        sa = a;
        sb = b;
        if (b == 32'd0) return want_rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return want_rem ? 32'd0 : 32'h8000_0000;
        if (sgn) return want_rem ? 32'(sa % sb) : 32'(sa / sb);
        return want_rem ? (a % b) : (a / b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge, then scramble the inputs
    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        start   = 1'b1;
        funct3  = f3;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        tick();
        start   = 1'b0;
        funct3  = 3'($urandom);
        rs1_val = $urandom;
        rs2_val = $urandom;
        rd_in   = 5'($urandom);
    endtask

    // Called just after the accepting edge; lat counts edges from acceptance
    task automatic wait_done(output int lat, output int stalls);
        lat    = 1;
        stalls = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (stall === 1'b1) stalls++;
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int          lat;
        int          stalls;
        int          exp_lat;
        logic        sgn;
        logic [31:0] exp_res;
        sgn     = (f3 == 3'b100) || (f3 == 3'b110);
        exp_res = model(f3, a, b);
        exp_lat = ((b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 2 : 35;
        launch(f3, a, b, rd);
        wait_done(lat, stalls);
        chk({tag, "_done"},    {31'd0, done}, 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_stalls"},  32'(stalls), 32'(exp_lat - 1));
        chk({tag, "_result"},  result, exp_res);
        chk({tag, "_rd"},      {27'd0, rd_out}, {27'd0, rd});
        chk({tag, "_nostall"}, {31'd0, stall}, 32'd0);
        tick();
        chk({tag, "_strobe"},  {31'd0, done}, 32'd0);
    endtask

    initial begin
        int          lat;
        int          stalls;
        int          seen;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        rst     = 1'b1;
        start   = 1'b0;
        flush   = 1'b0;
        funct3  = 3'd0;
        rs1_val = 32'd0;
        rs2_val = 32'd0;
        rd_in   = 5'd0;
        tick();
        tick();
        chk("reset_stall",  {31'd0, stall}, 32'd0);
        chk("reset_done",   {31'd0, done},  32'd0);
        chk("reset_result", result,          32'd0);
        chk("reset_rd",     {27'd0, rd_out}, 32'd0);
        rst = 1'b0;
        tick();

        // Directed arithmetic cases
        run_op("divu_100_7",  3'b101, 32'd100, 32'd7, 5'd5);
        chk("divu_100_7_value", result, 32'd14);
        run_op("remu_100_7",  3'b111, 32'd100, 32'd7, 5'd5);
        run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6);
        run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7);
        run_op("div_7_m2",    3'b100, 32'd7, 32'hFFFF_FFFE, 5'd8);
        run_op("rem_7_m2",    3'b110, 32'd7, 32'hFFFF_FFFE, 5'd8);
        run_op("div_42_0",    3'b100, 32'd42, 32'd0, 5'd10);
        run_op("rem_42_0",    3'b110, 32'd42, 32'd0, 5'd11);
        run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        run_op("divu_big",    3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
        run_op("f3_000_divu", 3'b000, 32'hFFFF_FFF0, 32'd3, 5'd15);
        run_op("divu_max_1",  3'b101, 32'hFFFF_FFFF, 32'd1, 5'd16);

        // Start together with flush in IDLE is ignored
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        chk("idle_flush_start_ignored", {31'd0, stall}, 32'd0);

        // Flush during the 10th CALC cycle
        launch(3'b101, 32'h1234_5678, 32'd13, 5'd9);
        tick();
        repeat (9) tick();
        chk("flush_busy_before", {31'd0, stall}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_stall_low", {31'd0, stall}, 32'd0);
        chk("flush_done_low",  {31'd0, done},  32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        chk("flush_no_done", 32'(seen), 32'd0);
        run_op("after_flush_divu_9_3", 3'b101, 32'd9, 32'd3, 5'd4);

        // Reset in the middle of CALC clears every output
        launch(3'b100, 32'hDEAD_BEEF, 32'd77, 5'd17);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_stall",  {31'd0, stall}, 32'd0);
        chk("midrst_done",   {31'd0, done},  32'd0);
        chk("midrst_result", result,          32'd0);
        chk("midrst_rd",     {27'd0, rd_out}, 32'd0);
        tick();

        // Start held through DONE: ignored there, accepted in the next IDLE
        launch(3'b101, 32'd1000, 32'd10, 5'd3);
        wait_done(lat, stalls);
        chk("hold_first_done",   {31'd0, done}, 32'd1);
        chk("hold_first_result", result, 32'd100);
        start   = 1'b1;
        funct3  = 3'b111;
        rs1_val = 32'd1000;
        rs2_val = 32'd7;
        rd_in   = 5'd21;
        tick();
        chk("start_in_done_ignored", {31'd0, stall}, 32'd0);
        tick();
        chk("start_in_idle_accepted", {31'd0, stall}, 32'd1);
        start = 1'b0;
        wait_done(lat, stalls);
        chk("hold_second_latency", 32'(lat), 32'd35);
        chk("hold_second_result",  result, model(3'b111, 32'd1000, 32'd7));
        chk("hold_second_rd",      {27'd0, rd_out}, 32'd21);
        tick();

        // Random operations, biased toward the special operand values
        for (int i = 0; i < 16; i++) begin
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'(4 + $urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 1000);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_op("rand", f3, a, b, 5'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
